// File: rtl/tff_mod_counter.sv
// tff_mod_counter
// Parametrised modulo up/down counter whose state bits are T flip-flops.
// Supports count enable, direction, synchronous load with clamping,
// a registered Gray-coded copy of the count, a combinational terminal-count
// strobe and a sticky wrap flag.
//
// Data flow:
//   q_q (binary state) --> next-count selection --> q_d
//   t_vec = q_d ^ q_q       (each state bit toggles when t_vec bit is 1)
//   gray_d = q_d ^ (q_d >> 1), registered alongside the count
//   wrapped_d = wrap_evt | (wrapped_q & ~clr_wrap)
//
// All range comparisons use WIDTH+1 bits so that MODULUS = 2**WIDTH is
// representable and MODULUS-1 never needs a truncating expression.

module tff_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             wrapped
);

  // ---------------------------------------------------------------------
  // Extended-width constants
  // ---------------------------------------------------------------------
  // MOD_EXT holds MODULUS itself (may equal 2**WIDTH), MAX_EXT the largest
  // legal count. Both live in WIDTH+1 bits.
  localparam logic [WIDTH:0] MOD_EXT  = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0] ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] MAX_EXT  = MOD_EXT - ONE_EXT;
  localparam logic [WIDTH:0] ZERO_EXT = '0;

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_d;
  logic             wrapped_q;
  logic             wrapped_d;

  // ---------------------------------------------------------------------
  // Decoded state
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   next_ext;
  logic             q_at_max;
  logic             q_at_zero;
  logic             q_out_of_range;
  logic             load_over;
  logic             wrap_evt;

  assign q_ext    = {1'b0, q_q};
  assign load_ext = {1'b0, load_val};

  // Range decode of the current count and of the load value.
  always_comb begin
    q_at_max       = (q_ext == MAX_EXT);
    q_at_zero      = (q_ext == ZERO_EXT);
    q_out_of_range = (q_ext >= MOD_EXT);
    load_over      = (load_ext >= MOD_EXT);
  end

  // Next-count selection: load beats count, count beats hold.
  // A wrap event is raised only for a genuine modulo wrap; recovery from an
  // out-of-range state (X/SEU) lands on 0 or MAX silently.
  always_comb begin
    next_ext = q_ext;
    wrap_evt = 1'b0;
    if (load) begin
      next_ext = load_over ? MAX_EXT : load_ext;
    end else if (en) begin
      if (up) begin
        if (q_out_of_range) begin
          next_ext = ZERO_EXT;
        end else if (q_at_max) begin
          next_ext = ZERO_EXT;
          wrap_evt = 1'b1;
        end else begin
          next_ext = q_ext + ONE_EXT;
        end
      end else begin
        if (q_out_of_range) begin
          next_ext = MAX_EXT;
        end else if (q_at_zero) begin
          next_ext = MAX_EXT;
          wrap_evt = 1'b1;
        end else begin
          next_ext = q_ext - ONE_EXT;
        end
      end
    end
  end

  // Narrow the extended next value back to WIDTH bits. Every path above
  // already stays below MOD_EXT; the guard keeps the narrowing provably
  // lossless and forces a legal value should that ever not hold.
  always_comb begin
    q_d = '0;
    if (next_ext < MOD_EXT) begin
      q_d = next_ext[WIDTH-1:0];
    end
  end

  // Toggle vector for the T flip-flops and the Gray copy of the next count.
  always_comb begin
    t_vec  = q_d ^ q_q;
    gray_d = q_d ^ (q_d >> 1);
  end

  // Sticky wrap flag: a wrap in the same cycle as clr_wrap keeps it set.
  always_comb begin
    wrapped_d = wrap_evt | (wrapped_q & ~clr_wrap);
  end

  // T flip-flop bank: each count bit inverts when its toggle bit is set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_q ^ t_vec;
    end
  end

  // Registered Gray copy and wrap flag, updated on the same edge as the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gray_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      gray_q    <= gray_d;
      wrapped_q <= wrapped_d;
    end
  end

  // Terminal count: high in the cycle whose edge will perform a wrap.
  always_comb begin
    tc = en & ~load & ((up & q_at_max) | (~up & q_at_zero));
  end

  assign Q       = q_q;
  assign gray    = gray_q;
  assign wrapped = wrapped_q;

endmodule
